ifetch_stage: RTL and testbench
===============================

Name: ifetch_stage

Overview:
Instruction fetch stage of the cpu pipeline. It sits directly upstream of the decode / register-file read stage. It issues sequential word fetches to instruction memory and buffers returned instructions, tagged with their PC, in a small prefetch FIFO. It delivers them to decode over a valid/ready handshake and handles branch redirects, including responses still in flight.

Parameters:
ADDR_W, 32, byte-address width of PC and imem_addr
DATA_W, 32, instruction width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 0, first fetch address after reset (word aligned)

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request pending; held high until imem_rvalid
imem_addr  output  ADDR_W  fetch address; stable while imem_req high and no rvalid
imem_rvalid  input  1  response for the pending request; only valid while imem_req high
imem_rdata  input  DATA_W  instruction word, valid with imem_rvalid
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  ADDR_W  redirect target; bits [1:0] forced to 0
if_valid  output  1  FIFO head valid toward decode
if_instr  output  DATA_W  FIFO head instruction
if_pc  output  ADDR_W  PC of FIFO head instruction
id_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (async, immediate):
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
  - FIFO empty, storage cleared; fetch_pc=RESET_PC; state=ISSUE.
  - First imem_req=1 (addr RESET_PC) in the first cycle after rst deasserts.
- States: ISSUE (may request), WAIT (one request outstanding), DISCARD (outstanding response must be dropped). Only one request is outstanding at a time.
- Transfer rules:
  - Response accepted in any cycle with imem_req=1 && imem_rvalid=1, earliest the cycle after req rises.
  - Decode pop = if_valid && id_ready; pop while empty is ignored.
- occ_next = count + push - pop.
- A new request may be raised at an edge only if occ_next < DEPTH. This guarantees no overflow.
- ISSUE:
  - If occ_next < DEPTH: imem_req<=1, imem_addr<=fetch_pc, go WAIT.
  - Otherwise imem_req<=0 and stay in ISSUE.
- WAIT, on rvalid:
  - Push {fetch_pc, rdata}; fetch_pc += 4 (wraps modulo 2^ADDR_W).
  - If occ_next < DEPTH: issue next address the same edge; req stays high, so back-to-back yields 1 instr/cycle.
  - Otherwise drop req and go ISSUE.
- WAIT, no rvalid: hold req and addr.
- Redirect (highest priority, any state):
  - FIFO flushed, no pop counted, if_valid=0 next cycle; fetch_pc<=redirect_pc&~3.
  - If a request is outstanding and rvalid is not in the same cycle: imem_req stays high on the old address; go DISCARD.
  - If rvalid is in the same cycle: the response is dropped (not pushed); imem_req<=1, imem_addr<=redirect target; go WAIT.
  - If no request is outstanding: imem_req<=1 at the target next cycle; go WAIT.
- DISCARD:
  - On rvalid: data dropped; immediately request fetch_pc (req stays high, addr updates); go WAIT.
  - A further redirect in DISCARD only updates fetch_pc.
- Simultaneous push and pop: both occur; count unchanged. Pointers wrap modulo DEPTH.
- if_instr/if_pc come from the FIFO head. While empty they hold the last head value (0 after reset); they are don't-care when if_valid=0.
- Decode sees an instruction one cycle after the push edge. Minimum latency from request to if_valid is 2 cycles with 1-cycle memory.

Test Plan:
- Reset release, memory answers 1 cycle after every req, id_ready=1:
  - imem_addr sequence 0,4,8,12…
  - if_pc follows with if_instr matching memory.
  - Sustained 1 instr/cycle after fill.
- id_ready=0, DEPTH=4:
  - Exactly 4 instructions buffered (PCs 0,4,8,12); imem_req drops to 0; no 5th request.
  - Raising id_ready resumes requests at addr 16 with no lost or duplicated PC.
- Memory latency 3 cycles, redirect_pc=0x103 asserted 1 cycle after req for addr 8:
  - Addr-8 response discarded; next imem_addr=0x100.
  - Next if_pc=0x100; if_valid=0 the cycle after redirect.
- Redirect to 0x40 in the same cycle as rvalid for addr 4:
  - Addr-4 data never reaches if_valid; imem_addr=0x40 the next cycle; DISCARD not entered.
- Redirect in same cycle as a decode pop with FIFO holding 3:
  - FIFO empty next cycle; only the popped instruction is consumed.
- Assert rst mid-stream while in WAIT with FIFO half full:
  - Outputs go to reset values asynchronously.
  - After release, fetch restarts at RESET_PC; a late rvalid while imem_req=0 is ignored.

Source files
------------

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage: sequential imem fetch, prefetch FIFO, branch redirect
//
// Ports:
//   clk, rst                  pipeline clock, asynchronous active-high reset
//   imem_req, imem_addr       fetch request toward instruction memory (one outstanding)
//   imem_rvalid, imem_rdata   response for the pending request
//   redirect_valid/_pc        taken branch/jump: flush buffered instructions, refetch from target
//   if_valid, if_instr, if_pc FIFO head toward decode
//   id_ready                  decode accepts the head this cycle
module ifetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        DISCARD
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
    logic [ADDR_W-1:0] imem_addr_n;
    logic              imem_req_n;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [PTR_W:0]    count, occ_next;

    logic              rsp, push, pop, room;
    logic [ADDR_W-1:0] target, seq_pc;

    assign rsp      = imem_req && imem_rvalid;
    assign push     = rsp && (state == WAIT) && !redirect_valid;
    // A redirect flushes everything, so a simultaneous pop needs no bookkeeping.
    assign pop      = if_valid && id_ready && !redirect_valid;
    assign occ_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    // occ_next never exceeds DEPTH (a power of two), so its MSB alone marks "full".
    assign room     = !occ_next[PTR_W];
    assign target   = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign seq_pc   = fetch_pc + ADDR_W'(4);

    assign if_valid = (count != '0);
    assign if_instr = instr_mem[rptr];
    assign if_pc    = pc_mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc_mem[wptr]    <= fetch_pc;
                instr_mem[wptr] <= imem_rdata;
                wptr            <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= occ_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ISSUE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            state     <= state_n;
            imem_req  <= imem_req_n;
            imem_addr <= imem_addr_n;
            fetch_pc  <= fetch_pc_n;
        end
    end

    always_comb begin
        state_n     = state;
        imem_req_n  = imem_req;
        imem_addr_n = imem_addr;
        fetch_pc_n  = fetch_pc;
        if (redirect_valid) begin
            fetch_pc_n = target;
            if (state == ISSUE || rsp) begin
                // Nothing outstanding after this edge: go straight to the target.
                imem_req_n  = 1'b1;
                imem_addr_n = target;
                state_n     = WAIT;
            end else begin
                // Old request still in flight; keep it stable and drop its data later.
                state_n = DISCARD;
            end
        end else begin
            case (state)
                ISSUE: begin
                    if (room) begin
                        imem_req_n  = 1'b1;
                        imem_addr_n = fetch_pc;
                        state_n     = WAIT;
                    end else begin
                        imem_req_n = 1'b0;
                    end
                end
                WAIT: begin
                    if (rsp) begin
                        fetch_pc_n = seq_pc;
                        if (room) begin
                            imem_addr_n = seq_pc;
                        end else begin
                            imem_req_n = 1'b0;
                            state_n    = ISSUE;
                        end
                    end
                end
                DISCARD: begin
                    if (rsp) begin
                        imem_addr_n = fetch_pc;
                        state_n     = WAIT;
                    end
                end
                default: begin
                    state_n = ISSUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - self-checking bench for ifetch_stage
module tb_ifetch_stage;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              id_ready;

    always #5 clk = ~clk;

    ifetch_stage #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // memory model and delivered-stream scoreboard
    int          lat;
    int          age;
    logic        prev_req, prev_rv;
    logic [31:0] prev_addr;
    logic [31:0] exp_pc;
    int          n_deliv = 0;

    typedef struct {
        logic        rv;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[14];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Called at a negedge: drive one cycle of inputs, score any delivery, advance to next negedge.
    task automatic tick(input logic rdy, input logic rv_en, input logic redir, input logic [31:0] rpc);
        logic rv;
        if (!prev_req || prev_rv) age = 0;
        else age = age + 1;
        rv = imem_req && rv_en && (age >= lat - 1);
        if (imem_req && prev_req && !prev_rv) chk("addr_stable", imem_addr, prev_addr);
        imem_rvalid    = rv;
        imem_rdata     = memf(imem_addr);
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (if_valid && rdy) begin
            chk("deliv_pc", if_pc, exp_pc);
            chk("deliv_instr", if_instr, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
        if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
        prev_req  = imem_req;
        prev_rv   = rv;
        prev_addr = imem_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk1("rst_valid", if_valid, 1'b0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        rst       = 1'b0;
        age       = 0;
        prev_req  = 1'b0;
        prev_rv   = 1'b0;
        prev_addr = RESET_PC;
        exp_pc    = RESET_PC;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] want_pc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (if_valid) begin
                found = 1'b1;
                break;
            end
            tick(1'b1, 1'b1, 1'b0, 32'h0);
        end
        chk1({name, "_seen"}, found, 1'b1);
        if (found) chk({name, "_pc"}, if_pc, want_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        rdy, redir;
        logic [31:0] rpc;
        int          d0;

        // Fill with decode stalled, then release: rows are {rvalid, id_ready, req, addr, valid, pc}.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'd4,  1'b1, 32'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'd12, 1'b1, 32'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'd12, 1'b1, 32'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'd12, 1'b1, 32'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'd12, 1'b1, 32'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'd16, 1'b1, 32'd4};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd4};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd8};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'd32, 1'b1, 32'd20};

        do_reset();
        for (int k = 0; k < 14; k++) begin
            chk1($sformatf("tbl%0d_req", k), imem_req, tbl[k].req);
            chk($sformatf("tbl%0d_addr", k), imem_addr, tbl[k].addr);
            chk1($sformatf("tbl%0d_valid", k), if_valid, tbl[k].vld);
            if (tbl[k].vld) begin
                chk($sformatf("tbl%0d_pc", k), if_pc, tbl[k].pc);
                chk($sformatf("tbl%0d_instr", k), if_instr, memf(tbl[k].pc));
            end
            imem_rvalid = tbl[k].rv;
            imem_rdata  = memf(imem_addr);
            id_ready    = tbl[k].rdy;
            @(posedge clk);
            @(negedge clk);
        end

        // Single-cycle memory, decode always ready: one instruction per cycle.
        do_reset();
        lat = 1;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 2; k < 10; k++) begin
            chk($sformatf("seq%0d_addr", k), imem_addr, 32'(4 * (k - 1)));
            chk1($sformatf("seq%0d_valid", k), if_valid, 1'b1);
            chk($sformatf("seq%0d_pc", k), if_pc, 32'(4 * (k - 2)));
            tick(1'b1, 1'b1, 1'b0, 32'h0);
        end

        // Latency 3, redirect to 0x103 one cycle after the addr-8 request rises.
        do_reset();
        lat = 3;
        repeat (8) tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk1("rd3_req", imem_req, 1'b1);
        chk("rd3_addr8", imem_addr, 32'h8);
        tick(1'b1, 1'b1, 1'b1, 32'h103);
        chk("rd3_hold", imem_addr, 32'h8);
        chk1("rd3_flush", if_valid, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rd3_newaddr", imem_addr, 32'h100);
        wait_valid("rd3", 32'h100);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect to 0x40 coinciding with the addr-4 response.
        do_reset();
        lat = 1;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rsame_addr4", imem_addr, 32'h4);
        tick(1'b1, 1'b1, 1'b1, 32'h40);
        chk("rsame_addr", imem_addr, 32'h40);
        chk1("rsame_req", imem_req, 1'b1);
        chk1("rsame_flush", if_valid, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rsame_next", imem_addr, 32'h44);
        chk1("rsame_valid", if_valid, 1'b1);
        chk("rsame_pc", if_pc, 32'h40);
        repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect together with a pop while three instructions are buffered.
        do_reset();
        lat = 1;
        repeat (4) tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk1("rpop_valid", if_valid, 1'b1);
        chk("rpop_head", if_pc, 32'h0);
        tick(1'b1, 1'b0, 1'b1, 32'h200);
        chk1("rpop_empty", if_valid, 1'b0);
        chk("rpop_hold", imem_addr, 32'hC);
        wait_valid("rpop", 32'h200);
        repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Asynchronous reset mid-stream in WAIT with two entries buffered, then a stray rvalid.
        do_reset();
        lat = 2;
        repeat (5) tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk1("mrst_pre_req", imem_req, 1'b1);
        chk("mrst_pre_addr", imem_addr, 32'h8);
        chk1("mrst_pre_valid", if_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("mrst_req", imem_req, 1'b0);
        chk("mrst_addr", imem_addr, RESET_PC);
        chk1("mrst_valid", if_valid, 1'b0);
        chk("mrst_instr", if_instr, 32'h0);
        chk("mrst_pc", if_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        id_ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("mrst_late_valid", if_valid, 1'b0);
        chk1("mrst_restart_req", imem_req, 1'b1);
        chk("mrst_restart_addr", imem_addr, RESET_PC);
        age       = 0;
        prev_req  = 1'b0;
        prev_rv   = 1'b0;
        prev_addr = RESET_PC;
        exp_pc    = RESET_PC;
        wait_valid("mrst", RESET_PC);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Randomized traffic: variable latency, stalls, redirects (some near address wrap).
        do_reset();
        d0 = n_deliv;
        for (int n = 0; n < 3000; n++) begin
            lat   = $urandom_range(1, 3);
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 24) == 0);
            rpc   = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | {28'b0, rpc[3:0]};
            tick(rdy, 1'b1, redir, rpc);
        end
        chk1("rand_progress", (n_deliv - d0) > 300, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
